// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FWFT FIFO controller.
package fifo_pkg;

   typedef enum logic [1:0] {OUT_EMPTY, OUT_ONE, OUT_TWO} out_state_e;

   // Occupancy between two wrapping pointers that are ptr_w bits wide.
   function automatic logic [31:0] fifo_level(input logic [31:0] wptr,
                                              input logic [31:0] rptr,
                                              input int unsigned ptr_w);
      logic [31:0] mask;
      mask = (ptr_w >= 32) ? '1 : ((32'd1 << ptr_w) - 32'd1);
      return (wptr - rptr) & mask;
   endfunction

endpackage

// File: rtl/simple_dpram_logic.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
module simple_dpram_logic #(
   parameter int unsigned ADDR_WIDTH        = 8,
   parameter int unsigned DATA_WIDTH        = 8,
   parameter string       RD_DUR_WR_USE_NEW = "false",
   parameter string       DOUT_REG          = "false"
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   generate
      if (RD_DUR_WR_USE_NEW == "true") begin : g_rd_new
         always_ff @(posedge clk_i) begin
            if (re_i) begin
               rd_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
            end
         end
      end else begin : g_rd_old
         always_ff @(posedge clk_i) begin
            if (re_i) begin
               rd_q <= mem_q[raddr_i];
            end
         end
      end

      if (DOUT_REG == "true") begin : g_dout_reg
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk_i) begin
            dout_q <= rd_q;
         end
         assign rdata_o = dout_q;
      end else begin : g_dout_comb
         assign rdata_o = rd_q;
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_fwft_ctrl.sv
// First-word-fall-through FIFO: RAM pointers, occupancy/status and a 2-entry
// prefetched output stage giving full-throughput valid/ready on both sides.
module sync_fifo_fwft_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned AFULL_LVL  = 2**ADDR_WIDTH - 4,
   parameter int unsigned AEMPTY_LVL = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o
);

   localparam int unsigned PtrW = ADDR_WIDTH + 1;
   localparam logic [PtrW-1:0] DepthC  = PtrW'(2**ADDR_WIDTH);
   localparam logic [PtrW-1:0] AfullC  = PtrW'(AFULL_LVL);
   localparam logic [PtrW-1:0] AemptyC = PtrW'(AEMPTY_LVL);

   logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PtrW-1:0]       count_q, count_d;
   logic [PtrW-1:0]       ram_occ;
   out_state_e            out_q, out_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic                  s_ready_q, s_ready_d;
   logic                  full_q, full_d, empty_q, empty_d;
   logic                  afull_q, afull_d, aempty_q, aempty_d;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  push, pop, cap, ren, m_valid;
   logic [1:0]            out_n;

   assign m_valid = (out_q != OUT_EMPTY);
   assign ram_occ = PtrW'(fifo_level(32'(wptr_q), 32'(rptr_q), PtrW));

   always_comb begin
      push       = s_valid_i & s_ready_q & ~clr_i;
      pop        = m_valid & m_ready_i & ~clr_i;
      cap        = inflight_q;
      out_n      = 2'd0;
      out_d      = out_q;
      head_d     = head_q;
      tail_d     = tail_q;

      unique case (out_q)
         OUT_ONE: out_n = 2'd1;
         OUT_TWO: out_n = 2'd2;
         default: out_n = 2'd0;
      endcase

      // Words held or on their way after this pop must stay below two.
      ren = (ram_occ != '0) && ~clr_i &&
            (({1'b0, out_n} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

      wptr_d     = wptr_q + PtrW'(push);
      rptr_d     = rptr_q + PtrW'(ren);
      inflight_d = ren;
      count_d    = count_q + PtrW'(push) - PtrW'(pop);

      unique case (out_q)
         OUT_EMPTY: begin
            if (cap) begin
               head_d = ram_rdata;
               out_d  = OUT_ONE;
            end
         end
         OUT_ONE: begin
            if (cap && pop) begin
               head_d = ram_rdata;
            end else if (cap) begin
               tail_d = ram_rdata;
               out_d  = OUT_TWO;
            end else if (pop) begin
               out_d  = OUT_EMPTY;
            end
         end
         OUT_TWO: begin
            if (pop) begin
               head_d = tail_q;
               if (cap) begin
                  tail_d = ram_rdata;
               end else begin
                  out_d = OUT_ONE;
               end
            end
         end
         default: out_d = OUT_EMPTY;
      endcase

      if (clr_i) begin
         wptr_d     = '0;
         rptr_d     = '0;
         inflight_d = 1'b0;
         count_d    = '0;
         out_d      = OUT_EMPTY;
         head_d     = '0;
         tail_d     = '0;
      end

      s_ready_d = ~clr_i & (count_d < DepthC);
      full_d    = (count_d == DepthC);
      empty_d   = (count_d == '0);
      afull_d   = (count_d >= AfullC);
      aempty_d  = (count_d <= AemptyC);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         out_q      <= OUT_EMPTY;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         s_ready_q  <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         out_q      <= out_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         s_ready_q  <= s_ready_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
      end
   end

   // Read address never equals the write address of the same cycle.
   simple_dpram_logic #(
      .ADDR_WIDTH        (ADDR_WIDTH),
      .DATA_WIDTH        (DATA_WIDTH),
      .RD_DUR_WR_USE_NEW ("false"),
      .DOUT_REG          ("false")
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
      .wdata_i (s_data_i),
      .re_i    (ren),
      .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (ram_rdata)
   );

   assign s_ready_o      = s_ready_q;
   assign m_valid_o      = m_valid;
   assign m_data_o       = head_q;
   assign count_o        = count_q;
   assign full_o         = full_q;
   assign empty_o        = empty_q;
   assign almost_full_o  = afull_q;
   assign almost_empty_o = aempty_q;

endmodule

// File: tb/tb_sync_fifo_fwft_ctrl.sv
// Randomized and directed bench for sync_fifo_fwft_ctrl against a word-index timing model.
module tb_sync_fifo_fwft_ctrl;

   localparam int AW     = 4;
   localparam int DW     = 8;
   localparam int DEPTH  = 1 << AW;
   localparam int AFULL  = 12;
   localparam int AEMPTY = 4;
   localparam int MAXW   = 32768;

   logic          clk = 1'b0;
   logic          rst, clr, s_valid, s_ready, m_valid, m_ready;
   logic [DW-1:0] s_data, m_data;
   logic [AW:0]   count;
   logic          full, empty, almost_full, almost_empty;

   always #5 clk = ~clk;

   sync_fifo_fwft_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .AFULL_LVL  (AFULL),
      .AEMPTY_LVL (AEMPTY)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clr_i          (clr),
      .s_valid_i      (s_valid),
      .s_ready_o      (s_ready),
      .s_data_i       (s_data),
      .m_valid_o      (m_valid),
      .m_ready_i      (m_ready),
      .m_data_o       (m_data),
      .count_o        (count),
      .full_o         (full),
      .empty_o        (empty),
      .almost_full_o  (almost_full),
      .almost_empty_o (almost_empty)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                                   tag, got, got, exp, exp, $time);
      end
   endtask

   // Model: words numbered in push order; a word is read from RAM once it was
   // pushed at an earlier edge, the word two ahead has been popped, and the
   // previous word has been read. It becomes the visible head one edge later.
   logic [DW-1:0] data_mem [MAXW];
   int            vis_e    [MAXW];
   int            wr_idx = 0, rd_idx = 0, hd_idx = 0, edge_n = 0;
   bit            exp_sready = 1'b0;

   function automatic bit exp_mvalid();
      return (hd_idx < rd_idx) && (vis_e[hd_idx] <= edge_n);
   endfunction

   task automatic check_outputs();
      int cnt;
      cnt = wr_idx - hd_idx;
      check_eq("count", int'(count), cnt);
      check_eq("full", int'(full), int'(cnt == DEPTH));
      check_eq("empty", int'(empty), int'(cnt == 0));
      check_eq("almost_full", int'(almost_full), int'(cnt >= AFULL));
      check_eq("almost_empty", int'(almost_empty), int'(cnt <= AEMPTY));
      check_eq("s_ready", int'(s_ready), int'(exp_sready));
      check_eq("m_valid", int'(m_valid), int'(exp_mvalid()));
      if (exp_mvalid()) check_eq("m_data", int'(m_data), int'(data_mem[hd_idx]));
   endtask

   // Called at a falling edge: drive, advance one rising edge, update model, check.
   task automatic step(input bit c, input bit sv, input logic [DW-1:0] sd, input bit mr);
      bit push, pop;
      clr     = c;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      push    = sv && exp_sready && !c;
      pop     = exp_mvalid() && mr && !c;
      @(posedge clk);
      edge_n++;
      if (c) begin
         rd_idx     = wr_idx;
         hd_idx     = wr_idx;
         exp_sready = 1'b0;
      end else begin
         if (pop) hd_idx++;
         if (rd_idx < wr_idx && rd_idx - 2 < hd_idx) begin
            vis_e[rd_idx] = edge_n + 1;
            rd_idx++;
         end
         if (push) begin
            data_mem[wr_idx] = sd;
            wr_idx++;
         end
         exp_sready = (wr_idx - hd_idx) < DEPTH;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drain(input string tag, input int budget);
      for (int t = 0; t < budget && wr_idx != hd_idx; t++) step(1'b0, 1'b0, '0, 1'b1);
      check_eq(tag, int'(empty), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got, n, start_wr;
      bit started;

      rst = 1'b1; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs();
      check_eq("rst_m_data", int'(m_data), 0);
      rst = 1'b0;
      step(1'b0, 1'b0, '0, 1'b0);
      check_eq("rst_s_ready_rise", int'(s_ready), 1);

      // Single word latency
      step(1'b0, 1'b1, 8'hA5, 1'b0);
      check_eq("lat_e0_mvalid", int'(m_valid), 0);
      check_eq("lat_e0_empty", int'(empty), 0);
      check_eq("lat_e0_count", int'(count), 1);
      step(1'b0, 1'b0, '0, 1'b0);
      check_eq("lat_e1_mvalid", int'(m_valid), 0);
      step(1'b0, 1'b0, '0, 1'b0);
      check_eq("lat_e2_mvalid", int'(m_valid), 1);
      check_eq("lat_e2_mdata", int'(m_data), 8'hA5);
      step(1'b0, 1'b0, '0, 1'b1);
      check_eq("lat_pop_empty", int'(empty), 1);

      // Fill to full, overflow attempt, drain in order
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      check_eq("fill_full", int'(full), 1);
      check_eq("fill_s_ready", int'(s_ready), 0);
      check_eq("fill_count", int'(count), DEPTH);
      step(1'b0, 1'b1, 8'hEE, 1'b0);
      check_eq("fill_17th_count", int'(count), DEPTH);
      got = 0;
      for (int t = 0; t < 100 && got < DEPTH; t++) begin
         if (exp_mvalid()) begin
            check_eq("fill_drain_data", int'(m_data), got);
            got++;
         end
         step(1'b0, 1'b0, '0, 1'b1);
         if (got == 1) check_eq("full_pop_s_ready", int'(s_ready), 1);
      end
      check_eq("fill_drain_words", got, DEPTH);
      check_eq("fill_drain_empty", int'(empty), 1);

      // Continuous streaming
      got = 0;
      started = 1'b0;
      for (int t = 0; t < 300 && got < 100; t++) begin
         if (started) check_eq("cont_gap", int'(m_valid), 1);
         if (exp_mvalid()) begin
            check_eq("cont_data", int'(m_data), got);
            got++;
            started = 1'b1;
         end
         step(1'b0, t < 100, 8'(t), 1'b1);
         if (t >= 2 && t <= 99) check_eq("cont_count", int'(count), 3);
      end
      check_eq("cont_words", got, 100);
      drain("cont_empty", 20);

      // Flush with simultaneous push and pop
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
      repeat (3) step(1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b1);
      check_eq("clr_count", int'(count), 0);
      check_eq("clr_m_valid", int'(m_valid), 0);
      check_eq("clr_m_data", int'(m_data), 0);
      check_eq("clr_s_ready", int'(s_ready), 0);
      step(1'b0, 1'b1, 8'h99, 1'b0);
      check_eq("clr_s_ready_back", int'(s_ready), 1);
      check_eq("clr_blocked_push", int'(count), 0);
      step(1'b0, 1'b1, 8'h3C, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
      check_eq("clr_first_word", int'(m_data), 8'h3C);
      drain("clr_empty", 10);

      // Almost-full / almost-empty thresholds
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0);
         check_eq("afull_fill", int'(almost_full), int'(i >= 12));
      end
      n = 12;
      for (int t = 0; t < 50 && n > 4; t++) begin
         bit mv;
         mv = exp_mvalid();
         step(1'b0, 1'b0, '0, 1'b1);
         if (mv) begin
            n--;
            check_eq("aempty_drain", int'(almost_empty), int'(n <= 4));
         end
      end
      check_eq("aempty_reached", n, 4);
      drain("levels_empty", 30);

      // Random traffic
      start_wr = wr_idx;
      for (int t = 0; t < 60000 && wr_idx - start_wr < 10000; t++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      check_eq("rand_words", wr_idx - start_wr >= 10000 ? 1 : 0, 1);
      drain("rand_empty", 100);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
